dm_responder: RTL

Data-memory responder for the RV64IF core's data port: the slave end of the core's `out_addr` / `out_wr_data` / `out_DM_wr_en` → `in_DM_data` interface. It holds a doubleword-addressed RAM array fronted by a posted write buffer. Reads are combinational, so the single-cycle core gets data in the same cycle. Buffered stores are forwarded to reads, so the buffer is architecturally invisible to the core. The block is instantiated beside `RV64IF_top` at system level.

---
 rtl/dm_responder.sv | 97 +++++++++
 1 files changed

// File: rtl/dm_responder.sv
// Data-memory responder: doubleword RAM with combinational reads and an optional posted write
// buffer with store-to-load forwarding, enabled by defining DM_WBUF_EN.
module dm_responder #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned WB_DEPTH = 4
) (
    input  logic                             in_Clk,
    input  logic                             in_Rst,
    input  logic [63:0]                      in_addr,
    input  logic [63:0]                      in_wr_data,
    input  logic                             in_wr_en,
    output logic [63:0]                      out_rd_data,
    output logic                             out_wb_full,
    output logic [$clog2(WB_DEPTH+1)-1:0]    out_wb_count
);
    localparam int unsigned CW = $clog2(WB_DEPTH + 1);

    logic [ADDR_W-1:0] idx;
    logic [63:0]       mem_q [2**ADDR_W];
    logic              unused_addr_bits;

    assign idx              = in_addr[ADDR_W+2:3];
    assign unused_addr_bits = ^{in_addr[63:ADDR_W+3], in_addr[2:0]};

`ifdef DM_WBUF_EN
    localparam int unsigned PW = $clog2(WB_DEPTH);

    logic [ADDR_W-1:0] wb_idx_q  [WB_DEPTH];
    logic [63:0]       wb_data_q [WB_DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full, drain;

    always_comb begin
        full    = (count_q == CW'(WB_DEPTH));
        // A full buffer drains while it accepts, so the array port never starves a store.
        drain   = ((count_q != '0) && !in_wr_en) || (full && in_wr_en);
        head_d  = drain ? head_q + PW'(1) : head_q;
        tail_d  = in_wr_en ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        if (in_wr_en && !drain) begin
            count_d = count_q + CW'(1);
        end else if (!in_wr_en && drain) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge in_Clk or posedge in_Rst) begin
        if (in_Rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge in_Clk) begin
        if (in_wr_en) begin
            wb_idx_q[tail_q]  <= idx;
            wb_data_q[tail_q] <= in_wr_data;
        end
        if (drain) begin
            mem_q[wb_idx_q[head_q]] <= wb_data_q[head_q];
        end
    end

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        out_rd_data = mem_q[idx];
        for (int unsigned k = 0; k < WB_DEPTH; k++) begin
            if ((CW'(k) < count_q) && (wb_idx_q[head_q + PW'(k)] == idx)) begin
                out_rd_data = wb_data_q[head_q + PW'(k)];
            end
        end
    end

    assign out_wb_full  = full;
    assign out_wb_count = count_q;
`else
    logic unused_rst;

    always_ff @(posedge in_Clk) begin
        if (in_wr_en) begin
            mem_q[idx] <= in_wr_data;
        end
    end

    assign out_rd_data  = mem_q[idx];
    assign out_wb_full  = 1'b0;
    assign out_wb_count = '0;
    assign unused_rst   = in_Rst;
`endif

endmodule
